// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter: writeback arbiter in front of the register file write port.
// Merges single-cycle ALU results (no backpressure, highest priority) with
// long-latency LSU results (valid/ready). LSU results that lose arbitration
// wait in a DEPTH-entry in-order FIFO. Write port outputs are registered.
//
// Optional feature macro: WB_PERF_EN adds saturating perf_stall/perf_conflict
// counters and their output ports.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   alu_valid/alu_rd/alu_data ALU result (always accepted)
//   lsu_valid/lsu_rd/lsu_data LSU result offer
//   lsu_ready                LSU accepted when lsu_valid && lsu_ready
//   waddr/we/wdata           registered register-file write port
//   busy                     holding FIFO non-empty
//   perf_stall/perf_conflict (WB_PERF_EN only) event counters
// -----------------------------------------------------------------------------
module wb_arbiter #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            lsu_ready,
    output logic [AW-1:0]   waddr,
    output logic            we,
    output logic [XLEN-1:0] wdata,
    output logic            busy
`ifdef WB_PERF_EN
    ,
    output logic [31:0]     perf_stall,
    output logic [31:0]     perf_conflict
`endif
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } entry_t;

    entry_t         mem [DEPTH];
    logic [PW-1:0]  rptr;
    logic [PW-1:0]  wptr;
    logic [CW-1:0]  count;

    logic           fifo_empty;
    logic           fifo_full;
    logic           lsu_acc;
    entry_t         head;

    logic           sel_valid;
    entry_t         sel;
    logic           push;
    logic           pop;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(DEPTH));

    // Full blocks acceptance even in a popping cycle.
    assign lsu_ready  = !rst && !fifo_full;
    assign lsu_acc    = lsu_valid && lsu_ready;
    assign busy       = !fifo_empty;

    // Head is only meaningful when non-empty; force zero otherwise.
    assign head = fifo_empty ? '0 : mem[rptr];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        ptr_inc = (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Slot selection: ALU, then FIFO head, then direct LSU bypass.
    always_comb begin
        sel_valid = 1'b0;
        sel       = '0;
        push      = 1'b0;
        pop       = 1'b0;
        if (alu_valid) begin
            sel_valid = 1'b1;
            sel.rd    = alu_rd;
            sel.data  = alu_data;
            push      = lsu_acc;
        end else if (!fifo_empty) begin
            sel_valid = 1'b1;
            sel       = head;
            pop       = 1'b1;
            push      = lsu_acc;
        end else if (lsu_acc) begin
            sel_valid = 1'b1;
            sel.rd    = lsu_rd;
            sel.data  = lsu_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= ptr_inc(wptr);
            if (pop)  rptr <= ptr_inc(rptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr].rd   <= lsu_rd;
            mem[wptr].data <= lsu_data;
        end
    end

    // Registered write port; rd==0 consumes the slot but suppresses we.
    always_ff @(posedge clk) begin
        if (rst) begin
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else begin
            we <= sel_valid && (sel.rd != '0);
            if (sel_valid) begin
                waddr <= sel.rd;
                wdata <= sel.data;
            end
        end
    end

`ifdef WB_PERF_EN
    logic stall_evt;
    logic conflict_evt;

    assign stall_evt    = lsu_valid && !lsu_ready;
    assign conflict_evt = alu_valid && (!fifo_empty || lsu_acc);

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall    <= '0;
            perf_conflict <= '0;
        end else begin
            if (stall_evt && (perf_stall != 32'hFFFF_FFFF))
                perf_stall <= perf_stall + 32'd1;
            if (conflict_evt && (perf_conflict != 32'hFFFF_FFFF))
                perf_conflict <= perf_conflict + 32'd1;
        end
    end
`endif

endmodule
